// File: rtl/zero_count_window.sv
// Windowed statistics stage: accumulates sum/min/max of per-word zero counts
// over a programmable window and emits one record per window through a small
// output FIFO. The input side never stalls; records that find the FIFO full
// are dropped and recorded in a sticky overflow flag.
module zero_count_window #(
    parameter int W_MAX      = 256,
    parameter int FIFO_DEPTH = 2,
    parameter int SUM_W      = $clog2(W_MAX * 32 + 1)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [5:0]                 in_y,
    input  logic [$clog2(W_MAX)-1:0]   cfg_len,
    input  logic                       flush,
    input  logic                       clr_ovf,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [SUM_W-1:0]           out_sum,
    output logic [5:0]                 out_min,
    output logic [5:0]                 out_max,
    output logic [$clog2(W_MAX):0]     out_words,
    output logic                       out_partial,
    output logic                       ovf
);

    localparam int LEN_W = $clog2(W_MAX);
    localparam int CNT_W = LEN_W + 1;
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int FCW   = $clog2(FIFO_DEPTH + 1);

    typedef enum logic {
        IDLE,
        ACC
    } state_t;

    typedef struct packed {
        logic [SUM_W-1:0] sum;
        logic [5:0]       minV;
        logic [5:0]       maxV;
        logic [CNT_W-1:0] words;
        logic             partial;
    } rec_t;

    state_t             state_q, state_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SUM_W-1:0]   sum_q, sum_d;
    logic [5:0]         min_q, min_d;
    logic [5:0]         max_q, max_d;

    rec_t               mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wrPtr_q, rdPtr_q;
    logic [FCW-1:0]     count_q;
    logic               ovf_q;

    logic [5:0]         yClamped;
    logic               closeWin;
    logic               reachedEnd;
    rec_t               closeRec;
    logic               fifoPop;
    logic               fifoPush;
    logic               fifoDrop;

    assign yClamped = (in_y > 6'd32) ? 6'd32 : in_y;

    // Window FSM: open on the first sample, accumulate, close on length or flush.
    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        cnt_d      = cnt_q;
        sum_d      = sum_q;
        min_d      = min_q;
        max_d      = max_q;
        closeWin   = 1'b0;
        reachedEnd = 1'b0;
        closeRec   = '0;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    len_d = cfg_len;
                    cnt_d = CNT_W'(1);
                    sum_d = SUM_W'(yClamped);
                    min_d = yClamped;
                    max_d = yClamped;
                    if ((cfg_len == '0) || flush) begin
                        closeWin         = 1'b1;
                        closeRec.partial = (cfg_len != '0);
                    end else begin
                        state_d = ACC;
                    end
                end
            end
            ACC: begin
                if (in_valid) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    sum_d = sum_q + SUM_W'(yClamped);
                    if (yClamped < min_q) min_d = yClamped;
                    if (yClamped > max_q) max_d = yClamped;
                end
                reachedEnd = (cnt_d == ({1'b0, len_q} + CNT_W'(1)));
                if (reachedEnd || flush) begin
                    closeWin         = 1'b1;
                    closeRec.partial = !reachedEnd;
                    state_d          = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (closeWin) begin
            closeRec.sum   = sum_d;
            closeRec.minV  = min_d;
            closeRec.maxV  = max_d;
            closeRec.words = cnt_d;
        end
    end

    // Window accumulator and FSM state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            len_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            min_q   <= '0;
            max_q   <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            min_q   <= min_d;
            max_q   <= max_d;
        end
    end

    // A full FIFO still accepts a push when the head is popped in the same cycle.
    always_comb begin
        fifoPop  = out_valid && out_ready;
        fifoPush = closeWin && ((count_q < FCW'(FIFO_DEPTH)) || fifoPop);
        fifoDrop = closeWin && !fifoPush;
    end

    // Record FIFO storage, pointers and occupancy; storage is cleared on reset so outputs read zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wrPtr_q <= '0;
            rdPtr_q <= '0;
            count_q <= '0;
        end else begin
            if (fifoPush) begin
                mem_q[wrPtr_q] <= closeRec;
                wrPtr_q <= (wrPtr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wrPtr_q + PTR_W'(1);
            end
            if (fifoPop) begin
                rdPtr_q <= (rdPtr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rdPtr_q + PTR_W'(1);
            end
            if (fifoPush && !fifoPop) begin
                count_q <= count_q + FCW'(1);
            end else if (fifoPop && !fifoPush) begin
                count_q <= count_q - FCW'(1);
            end
        end
    end

    // Sticky overflow flag; a new drop wins over a same-cycle clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (fifoDrop) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    assign out_valid   = (count_q != '0);
    assign out_sum     = mem_q[rdPtr_q].sum;
    assign out_min     = mem_q[rdPtr_q].minV;
    assign out_max     = mem_q[rdPtr_q].maxV;
    assign out_words   = mem_q[rdPtr_q].words;
    assign out_partial = mem_q[rdPtr_q].partial;
    assign ovf         = ovf_q;

endmodule

// File: doc/zero_count_window.md
# zero_count_window

Windowed statistics stage placed directly downstream of the 32-bit zero counter. It consumes the counter's per-word result (`valid_r`, `y`), accumulates the sum, minimum and maximum zero count over a programmable window of words, and emits one record per window on a valid/ready interface. The upstream counter has no backpressure, so this block never stalls its input. Records that cannot be buffered are dropped and flagged.

## Interface
- `W_MAX`, 256: maximum window length in words. Must be a power of two.
- `FIFO_DEPTH`, 2: number of output record buffer entries.
- `SUM_W`, `$clog2(W_MAX*32+1)` (14): width of the window sum.
- `clk  in  1`: clock.
- `rst  in  1`: reset, synchronous, active-high.
- `in_valid  in  1`: a counter result is present this cycle. Driven by the upstream `valid_r`.
- `in_y  in  6`: zero count of one 32-bit word. Legal range 0..32.
- `cfg_len  in  $clog2(W_MAX)`: window length minus one. Sampled only when a window opens.
- `flush  in  1`: close the currently open window at the end of this cycle.
- `clr_ovf  in  1`: clear the sticky overflow flag.
- `out_valid  out  1`: the output record is valid.
- `out_ready  in  1`: the consumer accepts the record.
- `out_sum  out  SUM_W`: sum of clamped `in_y` over the window.
- `out_min  out  6`: minimum clamped `in_y` in the window.
- `out_max  out  6`: maximum clamped `in_y` in the window.
- `out_words  out  $clog2(W_MAX)+1`: number of words in the window.
- `out_partial  out  1`: the window was closed by `flush` before reaching its full length.
- `ovf  out  1`: sticky flag; at least one record has been dropped.

## Operation
- Input clamp: `y_c = (in_y > 32) ? 32 : in_y`. All statistics use `y_c`.
- FSM state `IDLE`: no window is open.
  - On `in_valid`, open a window:
    - `len_q = cfg_len`, `cnt = 1`, `sum = y_c`, `min = max = y_c`.
    - If `cfg_len == 0`, close the window immediately; the state stays `IDLE`.
    - Otherwise go to `ACC`.
- FSM state `ACC`: a window is open.
  - On `in_valid`:
    - `cnt++`, `sum += y_c`.
    - `min` and `max` update against `y_c`.
  - The window closes when `cnt` reaches `len_q+1` after this update. The state returns to `IDLE`.
- Flush:
  - `flush` in `ACC` closes the window. If `in_valid` is high in the same cycle, that sample is included first.
  - `out_partial = 1` unless that sample also completes the window normally.
  - `flush` in `IDLE` with `in_valid` high opens a window and closes it at once: `out_words = 1`, `out_partial = (cfg_len != 0)`.
  - `flush` in `IDLE` with no `in_valid` has no effect and produces no record.
- Close: the record {sum, min, max, cnt, partial} is pushed into the output FIFO.
  - If the FIFO is full and no pop happens this cycle, the record is dropped and `ovf` is set.
  - If the FIFO is full and a pop happens in the same cycle, the push is accepted.
- `cfg_len` changes while in `ACC` have no effect on the open window.
- Pop: occurs when `out_valid && out_ready`. The head record advances next cycle.
- `ovf`:
  - Set has priority over `clr_ovf` in the same cycle.
  - Cleared only by `clr_ovf` or `rst`.
- Arithmetic:
  - `sum` is `SUM_W` bits and cannot overflow: `W_MAX * 32` fits.
  - `cnt` is `$clog2(W_MAX)+1` bits, so that `cnt == W_MAX` is representable.

## Timing
- Reset values:
  - State `IDLE`, FIFO empty.
  - `out_valid = 0`, `ovf = 0`.
  - `out_sum`, `out_min`, `out_max`, `out_words`, `out_partial` are all 0.
- Latency: the record of a window closing in cycle N is visible with `out_valid = 1` in cycle N+1. The FIFO output is registered.
- Sample acceptance: one sample per cycle, every cycle. `in_valid` is never back-pressured.
- Back-to-back windows: a sample arriving the cycle after a close opens the next window with no bubble.
- `out_*` data are stable while `out_valid && !out_ready`.
- `rst` mid-window: the open window and all FIFO contents are discarded; no record is emitted.
- Throughput: sustained 1 record/cycle (`cfg_len = 0`) with `out_ready` held high, with no drops.

## Test plan
- Window of four: `cfg_len = 3`, `in_y` = 4, 0, 32, 10 on consecutive cycles. Required response, one cycle after the last sample:
  - `out_sum = 46`, `out_min = 0`, `out_max = 32`, `out_words = 4`, `out_partial = 0`.
- Clamp plus gaps: `cfg_len = 1`, `in_y` = 40, then `in_valid` low for 3 cycles, then `in_y` = 1. Required response:
  - `out_sum = 33`, `out_max = 32`, `out_min = 1`.
- Flush:
  - `cfg_len = 7`, 3 samples of 5, then `flush` together with a 4th sample of 2. Required: `out_sum = 17`, `out_words = 4`, `out_partial = 1`, `out_min = 2`.
  - A `flush` alone in `IDLE` produces no record.
- Overflow:
  - `cfg_len = 0`, `out_ready = 0`, 3 samples. Required: 2 records held, the 3rd dropped, `ovf = 1`.
  - Then `clr_ovf` together with a 4th sample, FIFO still full. Required: `ovf` remains 1.
  - Then `clr_ovf` alone. Required: `ovf = 0`.
- Full-FIFO push with simultaneous pop: FIFO full, `out_ready = 1` in the same cycle a window closes. Required: no drop, `ovf` stays 0, records emerge in order.
- Reset mid-window: 2 of 4 samples accepted, then `rst` for 1 cycle, then 4 samples of 1. Required: exactly one record with `out_sum = 4`; all outputs read 0 during reset.
